// File: rtl/cpu_defs.sv
// cpu_defs: shared fetch-stage address defaults and redirect-source encoding
package cpu_defs;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT   = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI_DEFAULT   = 32'h0000_6FFC;
  typedef enum logic [2:0] {
    RS_RESET,
    RS_EXC,
    RS_ERET,
    RS_BR,
    RS_PEND,
    RS_SEQ
  } redirect_src_e;
endpackage

// File: rtl/pc_redirect_unit_pend_buf.sv
// pc_pend_buf: one-entry buffer holding a redirect target that arrived during a stall
module pc_pend_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] tgt_i,
  output logic             pend_o,
  output logic [WIDTH-1:0] tgt_o
);
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  always_comb begin
    pend_d = clr_i ? 1'b0 : cap_i ? 1'b1 : pend_q;
    tgt_d  = cap_i ? tgt_i : tgt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end
  assign pend_o = pend_q;
  assign tgt_o  = tgt_q;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with prioritised redirect, stall-safe pending target and fetch address-error flag
module pc_redirect_unit
  import cpu_defs::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEFAULT),
  parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(IMEM_LO_DEFAULT),
  parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(IMEM_HI_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] PC_F,
  output logic [WIDTH-1:0] PC4_F,
  output logic [WIDTH-1:0] PC8_F,
  output logic             adel_F,
  output logic             pend_F
);
  logic [WIDTH-1:0] pc_q, pc_d, pend_tgt;
  logic             pend, cap, clr;
  redirect_src_e    src;
  always_comb begin
    src  = reset ? RS_RESET : exc_req ? RS_EXC : eret_req ? RS_ERET :
           (pc_en && br_valid) ? RS_BR : (pc_en && pend) ? RS_PEND : RS_SEQ;
    pc_d = src == RS_RESET ? RESET_VEC :
           src == RS_EXC   ? EXC_VEC :
           src == RS_ERET  ? epc :
           src == RS_BR    ? br_target :
           src == RS_PEND  ? pend_tgt :
           pc_en           ? pc_q + WIDTH'(4) : pc_q;
    // Exception/eret flush the buffer; any advancing cycle consumes or supersedes it.
    cap  = !exc_req && !eret_req && !pc_en && br_valid;
    clr  = exc_req || eret_req || pc_en;
  end
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_d;
  end
  pc_pend_buf #(.WIDTH(WIDTH)) u_pend (
    .clk    (clk),
    .reset  (reset),
    .cap_i  (cap),
    .clr_i  (clr),
    .tgt_i  (br_target),
    .pend_o (pend),
    .tgt_o  (pend_tgt)
  );
  assign PC_F   = pc_q;
  assign PC4_F  = pc_q + WIDTH'(4);
  assign PC8_F  = pc_q + WIDTH'(8);
  assign adel_F = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);
  assign pend_F = pend;
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised next-generation fetch PC register for the pipelined MIPS core; sits at the head of F, drives instruction-memory address and the PC/PC+4/PC+8 values carried down the pipe.
- Adds, beyond a plain enable-gated PC:
  - a prioritised redirect (exception entry, eret return, branch/jump target);
  - a one-entry pending-redirect buffer, so a target presented during a stall is not lost;
  - fetch address-error detection.

Parameters:
- WIDTH, 32, address width in bits (≥ 8).
- RESET_VEC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_en  in  1  1 = PC may advance; 0 = stall (hold PC).
- br_valid  in  1  branch/jump redirect request this cycle.
- br_target  in  WIDTH  redirect target, valid when br_valid.
- exc_req  in  1  take exception: jump to EXC_VEC.
- eret_req  in  1  return from exception: jump to epc.
- epc  in  WIDTH  return address for eret_req.
- PC_F  out  WIDTH  current fetch address.
- PC4_F  out  WIDTH  PC_F + 4, modulo 2^WIDTH.
- PC8_F  out  WIDTH  PC_F + 8, modulo 2^WIDTH.
- adel_F  out  1  fetch address error for PC_F.
- pend_F  out  1  pending-redirect buffer occupied.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-high, sampled at rising edge of clk.
  - Reset takes priority over every other input, including pc_en=0.
- Reset values: PC_F = RESET_VEC, PC4_F = RESET_VEC+4, PC8_F = RESET_VEC+8, pend_F = 0, pending target = 0. adel_F follows combinationally; it is 0 for the default vectors.
- State: PC register (WIDTH); pending flag (1); pending target (WIDTH).
- Next-state priority at each rising edge, first match wins:
  1. reset: PC ← RESET_VEC; pend ← 0.
  2. exc_req: PC ← EXC_VEC; pend ← 0. Ignores pc_en; br_valid is discarded.
  3. eret_req: PC ← epc; pend ← 0. Ignores pc_en; br_valid is discarded.
  4. pc_en=0 (stall): PC holds.
     - If br_valid: pend ← 1, pending target ← br_target. A newer target overwrites an older pending one.
     - Else pend holds.
  5. pc_en=1 and br_valid: PC ← br_target; pend ← 0. A live target wins over a buffered one.
  6. pc_en=1 and pend=1: PC ← pending target; pend ← 0.
  7. Otherwise: PC ← PC+4, modulo 2^WIDTH (wraps to 0).
- Simultaneous exc_req and eret_req: exc_req wins.
- Latency: a redirect presented in cycle N appears on PC_F in cycle N+1, or on the first cycle after the edge where pc_en=1 if stalled.
- Outputs PC4_F, PC8_F and adel_F are combinational from the PC register only; there is no input-to-output combinational path.
- adel_F = 1 when PC_F[1:0] ≠ 0, PC_F < IMEM_LO, or PC_F > IMEM_HI. Comparisons are unsigned.
- The block never blocks or corrects a misaligned target. It loads it and flags it via adel_F; downstream logic raises AdEL.
- pend_F is a registered copy of the pending flag.

Decomposition:
- Shared package (cpu_defs): RESET_VEC_DEFAULT, EXC_VEC_DEFAULT, IMEM_LO/IMEM_HI defaults, and a redirect-source enum (RS_RESET, RS_EXC, RS_ERET, RS_BR, RS_PEND, RS_SEQ).
- One sub-module: pc_pend_buf, the one-entry pending-redirect register with capture/clear/overwrite logic.
- Priority mux and adel_F compare stay in the top module.

Test Plan:
- Reset then 3 free cycles (pc_en=1, no requests) → PC_F = 0x3000, 0x3004, 0x3008, 0x300C; PC8_F = 0x3014 in the last cycle; adel_F = 0, pend_F = 0 throughout.
- Stall with redirect: at PC=0x3010, pc_en=0 with br_valid=1, br_target=0x3400; hold 2 cycles, then pc_en=1, br_valid=0 → PC_F stays 0x3010 with pend_F=1, then PC_F = 0x3400 with pend_F=0.
- Overwrite and live-wins:
  - Overwrite: stalled, target 0x3400 then 0x3500 captured → pending target = 0x3500.
  - Live wins: on release with br_valid=1, br_target=0x3600 → PC_F = 0x3600, pend_F = 0.
- Exception priority: exc_req=1, eret_req=1, br_valid=1, pc_en=0 in the same cycle → PC_F = 0x4180, pend_F = 0. Next cycle eret_req=1, epc=0x3024 → PC_F = 0x3024.
- Address error:
  - br_target = 0x3002 → adel_F = 1.
  - br_target = 0x7000 → adel_F = 1.
  - br_target = 0x6FFC → adel_F = 0, and the next sequential step 0x7000 → adel_F = 1.
- Reset mid-stall with pend_F=1 → next edge PC_F = 0x3000, pend_F = 0. Separately, with WIDTH=32 and PC = 0xFFFF_FFFC, a sequential step wraps to 0x0000_0000 with adel_F = 1.
